rob_mw: RTL
===========

# rob_mw

Multi-issue reorder buffer for the out-of-order core, the parametrised successor to the single-lane ROB. It accepts up to `ENQ_WIDTH` in-order entries per cycle from dispatch/rename and marks entries done from `N_CDB` CDB ports. It retires up to `COMMIT_WIDTH` contiguous done entries per cycle to the commit stage. On a branch mispredict it truncates the tail to a checkpoint.

## Interface
- `ROB_DEPTH`, 64: entries; power of two, ≥ 2·max(`ENQ_WIDTH`,`COMMIT_WIDTH`).
- `ENQ_WIDTH`, 2: dispatch lanes.
- `COMMIT_WIDTH`, 2: commit lanes.
- `N_CDB`, 2: CDB completion ports.
- `PTR_W`, derived: $clog2(`ROB_DEPTH`). Pointers are `PTR_W`+1 bits with a wrap bit.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `cdb_pkt[N_CDB]`  in  cdb_pkt_t  completion broadcasts (`cdb_broadcast`, `cdb_rob_idx`, `rvfi_pkt`).
- `enq_valid[ENQ_WIDTH]`  in  1 each  dispatch lane valid; must be a prefix (lane i valid ⇒ lanes <i valid).
- `enq_pkt[ENQ_WIDTH]`  in  rob_pkt_t  dispatch payload.
- `enq_ready`  out  1  free slots ≥ `ENQ_WIDTH`.
- `enq_idx[ENQ_WIDTH]`  out  `PTR_W`+1  tail+i, including the wrap bit, for rename tagging and branch checkpoints.
- `commit_valid[COMMIT_WIDTH]`  out  1 each  entry head+i is occupied and done, and all lanes <i are valid.
- `commit_pkt[COMMIT_WIDTH]`  out  rob_pkt_t  entry at head+i.
- `commit_en[COMMIT_WIDTH]`  in  1 each  retire lane; prefix, subset of `commit_valid`.
- `flush`  in  1  mispredict squash.
- `flush_tail`  in  `PTR_W`+1  new tail (checkpointed `enq_idx`).
- `rob_head`  out  `PTR_W`  head slot index.
- `rob_count`  out  `PTR_W`+1  occupancy.
- `rob_empty`, `rob_full`  out  1  occupancy == 0 / == `ROB_DEPTH`.

## Operation
- State:
  - `head`, `tail` (`PTR_W`+1 bits);
  - per-slot `done` bit;
  - payload array.
  - `rob_count` = tail − head, modulo 2^(`PTR_W`+1).
- Enqueue: when `enq_ready` and `!flush`, lane i with `enq_valid[i]` writes slot (tail+i)[`PTR_W`-1:0] and clears its `done`. Tail advances by popcount(`enq_valid`). `enq_valid` while `!enq_ready` is dropped; dispatch must stall.
- Completion: each port with `cdb_broadcast` sets `done[cdb_rob_idx]` and writes the entry's `rvfi_pkt`. Ports target distinct indices. If two ports name the same index, the higher port number wins the payload write.
- Commit: head advances by popcount(`commit_en`). `commit_en` bits outside `commit_valid` are ignored (lane masked).
- Flush: tail ← `flush_tail`, and enqueue is suppressed that cycle. Commit and CDB writes proceed in the same cycle. `flush_tail` lies in [head+ncommit, tail]; anything outside that range is illegal and flagged by assertion.
- Squashed entries are not cleared; they are rewritten on reuse.

## Timing
- Reset (async assert, sync deassert):
  - head = tail = 0; all `done` = 0;
  - `rob_empty`=1, `rob_full`=0, `rob_count`=0;
  - `commit_valid`=0, `enq_ready`=1, `enq_idx[i]`=i.
- All outputs are combinational from registered state; there is no input-to-output path.
- CDB done → `commit_valid` at the earliest the next cycle (1-cycle latency). Enqueue → occupancy is visible the next cycle.
- Wrap: slot index is the low `PTR_W` bits; the wrap bit distinguishes full from empty.
- Simultaneous commit and enqueue at full: `enq_ready` uses current occupancy, so no same-cycle bypass of freed slots.
- Reset mid-operation: all pointers and done bits clear immediately; payload contents are don't-care.

## Configuration
- `ROB_RVFI_EN` defined: CDB writes store `rvfi_pkt` into the entry, and `commit_pkt.rvfi_pkt` is valid.
- Undefined: no rvfi storage or writes, and `commit_pkt.rvfi_pkt` reads as 0. This is for synthesis area.

## Structure
- In `rv32i_types`: `rob_pkt_t`, `cdb_pkt_t`, and the `ROB_DEPTH`/width defaults as localparams.
- One sub-module, `rob_done_tracker`: the done-bit vector with `N_CDB` set ports, enqueue clear ports, and `COMMIT_WIDTH` read ports.
- Pointer arithmetic and the payload array live in `rob_mw`.

## Test plan
- Reset with the queue holding entries (`rst`=0 mid-run) → next cycle `rob_empty`=1, `rob_count`=0, `commit_valid`=00, `enq_idx`={0,1}.
- Fill: 32 cycles of 2-lane enqueue with `ROB_DEPTH`=64 → `rob_full`=1, `enq_ready`=0. A 33rd enqueue is dropped and tail stays 64 (wrap bit set, slot 0).
- Out-of-order completion: CDB marks idx 1 then idx 0 → `commit_valid`=00 until idx 0 done, then 11 the next cycle. `commit_en`=11 → head +2.
- Partial commit: idx 0 and 2 done, idx 1 not → `commit_valid`=01. `commit_en`=11 retires only 1 entry.
- Flush with commit: head=4, tail=10, `flush_tail`=7, `commit_en`=01, enq lanes valid → next cycle head=5, tail=7, `rob_count`=2, no enqueue.
- Wrap-around: head=62, tail=66 → `commit_pkt` lanes read slots 62,63; `enq_idx`={66,67} maps to slots 2,3.

Source files
------------

// File: rtl/rob_mw_pkg.sv
// Shared ROB types: dispatch/commit payload, CDB broadcast packet and size defaults.
package rv32i_types;

   localparam int unsigned ROB_DEPTH_DEF    = 64;
   localparam int unsigned ENQ_WIDTH_DEF    = 2;
   localparam int unsigned COMMIT_WIDTH_DEF = 2;
   localparam int unsigned N_CDB_DEF        = 2;
   localparam int unsigned ROB_PTR_W        = $clog2(ROB_DEPTH_DEF);
   localparam int unsigned XLEN             = 32;

   typedef struct packed {
      logic [XLEN-1:0] rd_wdata;
      logic [XLEN-1:0] pc_wdata;
   } rvfi_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
      logic [4:0]      rd_addr;
      logic            rd_valid;
   } rob_base_t;

   typedef struct packed {
      rob_base_t base;
      rvfi_t     rvfi_pkt;
   } rob_pkt_t;

   typedef struct packed {
      logic               cdb_broadcast;
      logic [ROB_PTR_W:0] cdb_rob_idx;
      rvfi_t              rvfi_pkt;
   } cdb_pkt_t;

endpackage

// File: rtl/rob_mw_if.sv
// Dispatch, CDB, commit and flush signals between the core and the reorder buffer.
interface rob_mw_if #(
   parameter int unsigned ROB_DEPTH    = rv32i_types::ROB_DEPTH_DEF,
   parameter int unsigned ENQ_WIDTH    = rv32i_types::ENQ_WIDTH_DEF,
   parameter int unsigned COMMIT_WIDTH = rv32i_types::COMMIT_WIDTH_DEF,
   parameter int unsigned N_CDB        = rv32i_types::N_CDB_DEF
) ();
   import rv32i_types::*;

   localparam int unsigned PTR_W = $clog2(ROB_DEPTH);

   cdb_pkt_t         cdb_pkt      [N_CDB];
   logic             enq_valid    [ENQ_WIDTH];
   rob_pkt_t         enq_pkt      [ENQ_WIDTH];
   logic             enq_ready;
   logic [PTR_W:0]   enq_idx      [ENQ_WIDTH];
   logic             commit_valid [COMMIT_WIDTH];
   rob_pkt_t         commit_pkt   [COMMIT_WIDTH];
   logic             commit_en    [COMMIT_WIDTH];
   logic             flush;
   logic [PTR_W:0]   flush_tail;
   logic [PTR_W-1:0] rob_head;
   logic [PTR_W:0]   rob_count;
   logic             rob_empty;
   logic             rob_full;

   modport master (
      output cdb_pkt, enq_valid, enq_pkt, commit_en, flush, flush_tail,
      input  enq_ready, enq_idx, commit_valid, commit_pkt,
             rob_head, rob_count, rob_empty, rob_full
   );

   modport slave (
      input  cdb_pkt, enq_valid, enq_pkt, commit_en, flush, flush_tail,
      output enq_ready, enq_idx, commit_valid, commit_pkt,
             rob_head, rob_count, rob_empty, rob_full
   );

endinterface

// File: rtl/rob_mw_done_tracker.sv
// Per-slot done bits: CDB set ports, enqueue clear ports, commit-lane read ports.
module rob_done_tracker #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned N_SET = 2,
   parameter int unsigned N_CLR = 2,
   parameter int unsigned N_RD  = 2,
   parameter int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             set_en  [N_SET],
   input  logic [IDX_W-1:0] set_idx [N_SET],
   input  logic             clr_en  [N_CLR],
   input  logic [IDX_W-1:0] clr_idx [N_CLR],
   input  logic [IDX_W-1:0] rd_idx  [N_RD],
   output logic             rd_done [N_RD]
);

   logic [DEPTH-1:0] done_q;
   logic [DEPTH-1:0] done_d;

   // A freshly allocated slot always starts not-done, so clears take priority.
   always_comb begin : done_next
      done_d = done_q;
      for (int s = 0; s < N_SET; s++) begin
         if (set_en[s]) done_d[set_idx[s]] = 1'b1;
      end
      for (int c = 0; c < N_CLR; c++) begin
         if (clr_en[c]) done_d[clr_idx[c]] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin : done_reg
      if (!rst_n) done_q <= '0;
      else        done_q <= done_d;
   end

   always_comb begin : done_read
      for (int r = 0; r < N_RD; r++) begin
         rd_done[r] = done_q[rd_idx[r]];
      end
   end

endmodule

// File: rtl/rob_mw.sv
// Multi-issue reorder buffer: ENQ_WIDTH dispatch lanes, N_CDB completion ports,
// COMMIT_WIDTH commit lanes, tail truncation on flush. ROB_RVFI_EN adds rvfi storage.
module rob_mw
   import rv32i_types::*;
#(
   parameter int unsigned ROB_DEPTH    = ROB_DEPTH_DEF,
   parameter int unsigned ENQ_WIDTH    = ENQ_WIDTH_DEF,
   parameter int unsigned COMMIT_WIDTH = COMMIT_WIDTH_DEF,
   parameter int unsigned N_CDB        = N_CDB_DEF
) (
   input logic     clk,
   input logic     rst,
   rob_mw_if.slave rob
);

   localparam int unsigned PTR_W = $clog2(ROB_DEPTH);
   localparam int unsigned PW    = PTR_W + 1;

   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic [PW-1:0]    count;
   logic [PW-1:0]    head_nxt;
   logic [PW-1:0]    tail_nxt;
   logic [PW-1:0]    n_enq;
   logic [PW-1:0]    n_commit;
   logic             enq_fire;
   logic             enq_ready_int;

   logic [PTR_W-1:0] enq_slot [ENQ_WIDTH];
   logic             clr_en   [ENQ_WIDTH];
   logic [PTR_W-1:0] rd_slot  [COMMIT_WIDTH];
   logic             rd_done  [COMMIT_WIDTH];
   logic             cv       [COMMIT_WIDTH];
   logic             set_en   [N_CDB];
   logic [PTR_W-1:0] set_idx  [N_CDB];

   rob_base_t        base_mem [ROB_DEPTH];
`ifdef ROB_RVFI_EN
   rvfi_t            rvfi_mem [ROB_DEPTH];
`endif

   // Occupancy and status flags come only from registered pointers.
   assign count         = tail - head;
   assign enq_ready_int = (PW'(ROB_DEPTH) - count) >= PW'(ENQ_WIDTH);
   assign enq_fire      = enq_ready_int && !rob.flush;

   assign rob.enq_ready = enq_ready_int;
   assign rob.rob_count = count;
   assign rob.rob_head  = PTR_W'(head);
   assign rob.rob_empty = (count == '0);
   assign rob.rob_full  = (count == PW'(ROB_DEPTH));

   always_comb begin : enq_lanes
      n_enq = '0;
      for (int i = 0; i < ENQ_WIDTH; i++) begin
         rob.enq_idx[i] = tail + PW'(i);
         enq_slot[i]    = PTR_W'(tail + PW'(i));
         clr_en[i]      = enq_fire && rob.enq_valid[i];
         if (rob.enq_valid[i]) n_enq = n_enq + PW'(1);
      end
   end

   always_comb begin : commit_slots
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         rd_slot[i] = PTR_W'(head + PW'(i));
      end
   end

   // Commit lanes form a prefix of occupied, done entries; commit_en is masked by it.
   always_comb begin : commit_lanes
      logic chain;
      logic take;
      chain    = 1'b1;
      take     = 1'b1;
      n_commit = '0;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         cv[i]               = chain && (PW'(i) < count) && rd_done[i];
         chain               = cv[i];
         rob.commit_valid[i] = cv[i];
         if (take && cv[i] && rob.commit_en[i]) n_commit = n_commit + PW'(1);
         else                                   take     = 1'b0;
      end
   end

   always_comb begin : commit_read
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         rob.commit_pkt[i].base = base_mem[rd_slot[i]];
`ifdef ROB_RVFI_EN
         rob.commit_pkt[i].rvfi_pkt = rvfi_mem[rd_slot[i]];
`else
         rob.commit_pkt[i].rvfi_pkt = '0;
`endif
      end
   end

   always_comb begin : cdb_ports
      for (int p = 0; p < N_CDB; p++) begin
         set_en[p]  = rob.cdb_pkt[p].cdb_broadcast;
         set_idx[p] = PTR_W'(rob.cdb_pkt[p].cdb_rob_idx);
      end
   end

   assign head_nxt = head + n_commit;
   assign tail_nxt = rob.flush ? rob.flush_tail
                   : (enq_fire ? tail + n_enq : tail);

   always_ff @(posedge clk or negedge rst) begin : ptr_reg
      if (!rst) begin
         head <= '0;
         tail <= '0;
      end else begin
         head <= head_nxt;
         tail <= tail_nxt;
      end
   end

   // Payload is not reset; squashed entries are simply overwritten on reuse.
   always_ff @(posedge clk) begin : payload_wr
      for (int i = 0; i < ENQ_WIDTH; i++) begin
         if (clr_en[i]) base_mem[enq_slot[i]] <= rob.enq_pkt[i].base;
      end
   end

`ifdef ROB_RVFI_EN
   // Later ports are written last, so the higher port wins a shared index.
   always_ff @(posedge clk) begin : rvfi_wr
      for (int p = 0; p < N_CDB; p++) begin
         if (set_en[p]) rvfi_mem[set_idx[p]] <= rob.cdb_pkt[p].rvfi_pkt;
      end
   end
`endif

   rob_done_tracker #(
      .DEPTH (ROB_DEPTH),
      .N_SET (N_CDB),
      .N_CLR (ENQ_WIDTH),
      .N_RD  (COMMIT_WIDTH),
      .IDX_W (PTR_W)
   ) u_done (
      .clk     (clk),
      .rst_n   (rst),
      .set_en  (set_en),
      .set_idx (set_idx),
      .clr_en  (clr_en),
      .clr_idx (enq_slot),
      .rd_idx  (rd_slot),
      .rd_done (rd_done)
   );

   // Fields that carry no state in this configuration.
   logic unused_bits;
   always_comb begin : unused_sink
      unused_bits = 1'b0;
      for (int p = 0; p < N_CDB; p++) begin
         unused_bits = unused_bits ^ (|(rob.cdb_pkt[p].cdb_rob_idx >> PTR_W));
`ifndef ROB_RVFI_EN
         unused_bits = unused_bits ^ (^rob.cdb_pkt[p].rvfi_pkt);
`endif
      end
      for (int i = 0; i < ENQ_WIDTH; i++) begin
         unused_bits = unused_bits ^ (^rob.enq_pkt[i].rvfi_pkt);
      end
   end

   // The new tail must lie between the post-commit head and the current tail.
   logic [PW-1:0] flush_off;
   logic [PW-1:0] flush_span;
   assign flush_off  = rob.flush_tail - head_nxt;
   assign flush_span = tail - head_nxt;

   flush_tail_in_range: assert property (
      @(posedge clk) disable iff (!rst) rob.flush |-> (flush_off <= flush_span));

endmodule
